// File: rtl/spi_bus_arbiter.sv
// Two-requester round-robin arbiter in front of one SPI byte engine.
// Owns the chip-selects, times CS setup/hold and routes bytes through the engine.
module spi_bus_arbiter #(
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       tx_ready0,
    output logic       tx_ready1,
    input  logic       tx_valid0,
    input  logic       tx_valid1,
    input  logic [7:0] tx_byte0,
    input  logic [7:0] tx_byte1,
    output logic       rx_done0,
    output logic       rx_done1,
    output logic [7:0] rx_byte,
    output logic [1:0] cs_n,
    output logic       eng_start,
    output logic [7:0] eng_in_byte,
    input  logic       eng_done,
    input  logic [7:0] eng_out_byte,
    output logic [2:0] dbg_state
);

    localparam int SETUP_CYC = (CS_SETUP > 1) ? CS_SETUP : 1;
    localparam int HOLD_CYC  = ((CS_HOLD > 1) ? CS_HOLD : 1) + 1;
    localparam int CNT_MAX   = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CW        = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_READY = 3'd2;
    localparam logic [2:0] S_BUSY  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          last;
    logic          owner;
    logic          rst_q;
    logic [1:0]    gnt_q;
    logic [1:0]    rx_done_q;

    logic          pick;
    logic          own_req;
    logic          own_valid;
    logic [7:0]    own_byte;

    // A byte moves only on a cycle where the owner's tx_valid and tx_ready are both high;
    // tx_valid at any other time, or from the non-owner, has no effect.
    always_comb begin
        pick      = (req0 && req1) ? ~last : ~req0;
        own_req   = owner ? req1 : req0;
        own_valid = owner ? tx_valid1 : tx_valid0;
        own_byte  = owner ? tx_byte1 : tx_byte0;
    end

    // rst_q delays the first state change until the second edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_q       <= 1'b0;
            state       <= S_IDLE;
            cnt         <= '0;
            last        <= 1'b1;
            owner       <= 1'b0;
            gnt_q       <= 2'b00;
            rx_done_q   <= 2'b00;
            rx_byte     <= 8'h00;
            eng_start   <= 1'b0;
            eng_in_byte <= 8'h00;
        end else begin
            rst_q     <= 1'b1;
            eng_start <= 1'b0;
            rx_done_q <= 2'b00;
            if (rst_q) begin
                case (state)
                    S_IDLE: begin
                        if (req0 || req1) begin
                            owner <= pick;
                            last  <= pick;
                            gnt_q <= pick ? 2'b10 : 2'b01;
                            state <= S_SETUP;
                            cnt   <= '0;
                        end
                    end
                    S_SETUP: begin
                        if (cnt == SETUP_LAST) begin
                            state <= S_READY;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_READY: begin
                        if (own_valid) begin
                            eng_in_byte <= own_byte;
                            eng_start   <= 1'b1;
                            state       <= S_BUSY;
                            cnt         <= '0;
                        end else if (!own_req) begin
                            state <= S_HOLD;
                            cnt   <= '0;
                        end
                    end
                    S_BUSY: begin
                        if (eng_done) begin
                            rx_byte   <= eng_out_byte;
                            rx_done_q <= owner ? 2'b10 : 2'b01;
                            state     <= own_req ? S_READY : S_HOLD;
                            cnt       <= '0;
                        end
                    end
                    S_HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            state <= S_IDLE;
                            gnt_q <= 2'b00;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        gnt_q <= 2'b00;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign gnt0      = gnt_q[0];
    assign gnt1      = gnt_q[1];
    assign cs_n      = ~gnt_q;
    assign tx_ready0 = (state == S_READY) && !owner;
    assign tx_ready1 = (state == S_READY) && owner;
    assign rx_done0  = rx_done_q[0];
    assign rx_done1  = rx_done_q[1];
    assign dbg_state = state;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Randomised and directed bench for spi_bus_arbiter with a cycle-timed reference model,
// an engine model, and byte scoreboards.
`timescale 1ns/1ps
module tb_spi_bus_arbiter;

    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int SET_LEN  = (CS_SETUP > 1) ? CS_SETUP : 1;
    localparam int HOLD_LEN = (CS_HOLD > 1) ? CS_HOLD : 1;
    localparam int INF      = 32'h7fff_ffff;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] req_v = 2'b00;
    logic [1:0] tx_valid_v = 2'b00;
    logic [7:0] tx_byte_v [2];
    logic       eng_done = 1'b0;
    logic [7:0] eng_out_byte = 8'h00;

    logic       gnt0, gnt1, tx_ready0, tx_ready1, rx_done0, rx_done1, eng_start;
    logic [7:0] rx_byte, eng_in_byte;
    logic [1:0] cs_n;
    logic [2:0] dbg_state;

    spi_bus_arbiter #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
        .clk(clk), .reset(reset),
        .req0(req_v[0]), .req1(req_v[1]),
        .gnt0(gnt0), .gnt1(gnt1),
        .tx_ready0(tx_ready0), .tx_ready1(tx_ready1),
        .tx_valid0(tx_valid_v[0]), .tx_valid1(tx_valid_v[1]),
        .tx_byte0(tx_byte_v[0]), .tx_byte1(tx_byte_v[1]),
        .rx_done0(rx_done0), .rx_done1(rx_done1),
        .rx_byte(rx_byte), .cs_n(cs_n),
        .eng_start(eng_start), .eng_in_byte(eng_in_byte),
        .eng_done(eng_done), .eng_out_byte(eng_out_byte),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Timing expressed as absolute cycle numbers: when tx_ready opens, when CS releases.
    int         m_cyc = 0;
    bit         m_sync, m_has, m_busy;
    logic       m_ob, m_last;
    int         m_ready_from, m_rel;
    bit         prev_ready;
    logic [1:0] e_gnt, e_ready, e_rx_done;
    logic       e_start;
    logic [7:0] e_rx_byte, e_in_byte;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_sync = 0; m_has = 0; m_busy = 0; m_ob = 0; m_last = 1;
            m_ready_from = INF; m_rel = INF;
            e_gnt = 0; e_ready = 0; e_rx_done = 0; e_start = 0;
            e_rx_byte = 0; e_in_byte = 0;
        end else begin
            m_cyc++;
            prev_ready = m_has && e_ready[m_ob];
            e_start = 0;
            e_rx_done = 0;
            if (!m_sync) begin
                m_sync = 1;
            end else if (!m_has) begin
                if (req_v != 2'b00) begin
                    if (req_v == 2'b11) m_ob = !m_last;
                    else m_ob = req_v[1];
                    m_last = m_ob;
                    m_has = 1;
                    m_busy = 0;
                    m_ready_from = m_cyc + SET_LEN;
                    m_rel = INF;
                end
            end else if (m_rel != INF) begin
                if (m_cyc >= m_rel) begin
                    m_has = 0;
                    m_rel = INF;
                    m_ready_from = INF;
                end
            end else if (m_busy) begin
                if (eng_done) begin
                    e_rx_byte = eng_out_byte;
                    e_rx_done[m_ob] = 1'b1;
                    m_busy = 0;
                    if (req_v[m_ob]) m_ready_from = m_cyc;
                    else m_rel = m_cyc + HOLD_LEN + 1;
                end
            end else if (prev_ready) begin
                if (tx_valid_v[m_ob]) begin
                    m_busy = 1;
                    e_start = 1;
                    e_in_byte = tx_byte_v[m_ob];
                end else if (!req_v[m_ob]) begin
                    m_rel = m_cyc + HOLD_LEN + 1;
                end
            end
            e_gnt = 0;
            e_ready = 0;
            if (m_has) begin
                e_gnt[m_ob] = 1'b1;
                if (!m_busy && m_rel == INF && m_cyc >= m_ready_from) e_ready[m_ob] = 1'b1;
            end
        end
    end

    // ---------------- scoreboards + compare ----------------
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         gnt_order[$];
    int         starts = 0;
    int         rx_cnt [2];
    logic [1:0] prev_gnt = 2'b00;

    initial begin
        rx_cnt[0] = 0;
        rx_cnt[1] = 0;
    end

    always @(posedge clk or negedge reset) begin
        #1;
        chk("gnt", {6'b0, gnt1, gnt0}, {6'b0, e_gnt});
        chk("cs_n", {6'b0, cs_n}, {6'b0, ~e_gnt});
        chk("tx_ready", {6'b0, tx_ready1, tx_ready0}, {6'b0, e_ready});
        chk("rx_done", {6'b0, rx_done1, rx_done0}, {6'b0, e_rx_done});
        chk("eng_start", {7'b0, eng_start}, {7'b0, e_start});
        chk("rx_byte", rx_byte, e_rx_byte);
        chk("eng_in_byte", eng_in_byte, e_in_byte);
        if (eng_start) begin
            starts++;
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sb_tx: eng_start with byte %0h, expected no transfer", eng_in_byte);
            end else begin
                chk("sb_tx", eng_in_byte, exp_q.pop_front());
            end
        end
        if (rx_done0 || rx_done1) begin
            if (rx_done0) rx_cnt[0]++;
            if (rx_done1) rx_cnt[1]++;
            if (rx_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sb_rx: rx_done with byte %0h, expected no completion", rx_byte);
            end else begin
                chk("sb_rx", rx_byte, rx_q.pop_front());
            end
        end
        if (gnt0 && !prev_gnt[0]) gnt_order.push_back(0);
        if (gnt1 && !prev_gnt[1]) gnt_order.push_back(1);
        prev_gnt = {gnt1, gnt0};
    end

    // ---------------- engine model ----------------
    bit         eng_fixed = 0;
    int         eng_lat = 4;
    logic [7:0] eng_val = 8'h00;
    bit         spur_req = 0;

    initial begin
        int cnt;
        logic [7:0] b;
        cnt = 0;
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            if (!reset) begin
                cnt = 0;
            end else if (spur_req) begin
                eng_done = 1'b1;
                eng_out_byte = 8'hEE;
                spur_req = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    b = eng_fixed ? eng_val : 8'($urandom);
                    eng_out_byte = b;
                    eng_done = 1'b1;
                    rx_q.push_back(b);
                end
            end else if (eng_start) begin
                cnt = eng_fixed ? eng_lat : $urandom_range(1, 6);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_req(input int r, input int n, input logic [7:0] b0, input bit rnd, input int drop);
        logic [7:0] b;
        int base;
        bit ok;
        base = rx_cnt[r];
        b = b0;
        @(negedge clk);
        req_v[r] = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (rnd) b = 8'($urandom);
            tx_byte_v[r] = b;
            tx_valid_v[r] = 1'b1;
            ok = 0;
            for (int w = 0; w < 4000; w++) begin
                if ((r == 0) ? tx_ready0 : tx_ready1) begin
                    ok = 1;
                    break;
                end
                @(negedge clk);
            end
            chk($sformatf("accept_r%0d", r), {7'b0, ok}, 8'h01);
            if (ok) exp_q.push_back(b);
            @(negedge clk);
            b = b + 8'd1;
        end
        tx_valid_v[r] = 1'b0;
        if (drop >= 0) begin
            repeat (drop) @(negedge clk);
            req_v[r] = 1'b0;
        end
        ok = 0;
        for (int w = 0; w < 4000; w++) begin
            if (rx_cnt[r] >= base + n) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("rx_seen_r%0d", r), {7'b0, ok}, 8'h01);
        req_v[r] = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            if (cs_n == 2'b11) begin
                ok = 1;
                break;
            end
        end
        chk(name, {7'b0, ok}, 8'h01);
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int s0, r0, r1, g0, cnt;
        bit ok;
        tx_byte_v[0] = 8'h00;
        tx_byte_v[1] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", {6'b0, cs_n}, 8'h03);
        chk("rst_gnt", {6'b0, gnt1, gnt0}, 8'h00);
        chk("rst_tx_ready", {6'b0, tx_ready1, tx_ready0}, 8'h00);
        chk("rst_rx_byte", rx_byte, 8'h00);
        chk("rst_eng_in_byte", eng_in_byte, 8'h00);
        chk("rst_state", {5'b0, dbg_state}, 8'h00);
        reset = 1'b1;

        // spurious engine pulse while idle
        @(negedge clk);
        spur_req = 1;
        repeat (4) @(negedge clk);
        chk("spur_no_start", 8'(starts), 8'h00);
        chk("spur_no_rx", 8'(rx_cnt[0] + rx_cnt[1]), 8'h00);
        chk("spur_cs_n", {6'b0, cs_n}, 8'h03);

        // round-robin: tie, two bytes each, then tie again
        eng_fixed = 0;
        g0 = gnt_order.size();
        fork
            run_req(0, 2, 8'h10, 1'b1, -1);
            run_req(1, 2, 8'h20, 1'b1, -1);
        join
        wait_idle("rr_idle_a");
        fork
            run_req(0, 2, 8'h30, 1'b1, -1);
            run_req(1, 2, 8'h40, 1'b1, -1);
        join
        wait_idle("rr_idle_b");
        chk("rr_grants", 8'(gnt_order.size() - g0), 8'd4);
        if (gnt_order.size() >= g0 + 4) begin
            chk("rr_order0", 8'(gnt_order[g0]), 8'd0);
            chk("rr_order1", 8'(gnt_order[g0 + 1]), 8'd1);
            chk("rr_order2", 8'(gnt_order[g0 + 2]), 8'd0);
            chk("rr_order3", 8'(gnt_order[g0 + 3]), 8'd1);
        end

        // single byte with hand-computed timing
        eng_fixed = 1; eng_lat = 20; eng_val = 8'h3C;
        @(negedge clk);
        req_v[0] = 1'b1;
        @(posedge clk); #1;
        chk("t1_gnt0", {7'b0, gnt0}, 8'h01);
        chk("t1_cs_n", {6'b0, cs_n}, 8'h02);
        chk("t1_ready_k1", {7'b0, tx_ready0}, 8'h00);
        @(posedge clk); #1;
        chk("t1_ready_k2", {7'b0, tx_ready0}, 8'h00);
        @(posedge clk); #1;
        chk("t1_ready_k3", {7'b0, tx_ready0}, 8'h01);
        @(negedge clk);
        tx_valid_v[0] = 1'b1;
        tx_byte_v[0] = 8'hA5;
        exp_q.push_back(8'hA5);
        @(posedge clk); #1;
        chk("t1_start", {7'b0, eng_start}, 8'h01);
        chk("t1_in_byte", eng_in_byte, 8'hA5);
        chk("t1_ready_busy", {7'b0, tx_ready0}, 8'h00);
        @(negedge clk);
        tx_valid_v[0] = 1'b0;
        ok = 0;
        for (int w = 0; w < 100; w++) begin
            @(posedge clk); #1;
            if (rx_done0) begin
                ok = 1;
                break;
            end
        end
        chk("t1_rx_done", {7'b0, ok}, 8'h01);
        chk("t1_rx_byte", rx_byte, 8'h3C);
        @(negedge clk);
        req_v[0] = 1'b0;
        cnt = 0;
        for (int w = 0; w < 50; w++) begin
            @(posedge clk); #1;
            cnt++;
            if (cs_n == 2'b11) break;
        end
        chk("t1_release_cycles", 8'(cnt), 8'd4);
        chk("t1_gnt0_low", {7'b0, gnt0}, 8'h00);
        wait_idle("t1_idle");

        // burst of four bytes on requester 1
        eng_fixed = 0;
        s0 = starts; r0 = rx_cnt[0]; r1 = rx_cnt[1]; g0 = gnt_order.size();
        run_req(1, 4, 8'h01, 1'b0, -1);
        wait_idle("burst_idle");
        chk("burst_starts", 8'(starts - s0), 8'd4);
        chk("burst_rx1", 8'(rx_cnt[1] - r1), 8'd4);
        chk("burst_rx0", 8'(rx_cnt[0] - r0), 8'd0);
        chk("burst_one_grant", 8'(gnt_order.size() - g0), 8'd1);

        // illegal strobes: non-owner valid, valid during BUSY, idle eng_done
        s0 = starts; r1 = rx_cnt[1];
        tx_valid_v[1] = 1'b1;
        tx_byte_v[1] = 8'h77;
        run_req(0, 2, 8'h55, 1'b0, -1);
        wait_idle("illegal_idle");
        tx_valid_v[1] = 1'b0;
        spur_req = 1;
        repeat (4) @(negedge clk);
        chk("illegal_starts", 8'(starts - s0), 8'd2);
        chk("illegal_rx1", 8'(rx_cnt[1] - r1), 8'd0);
        chk("illegal_cs_n", {6'b0, cs_n}, 8'h03);

        // early release mid-byte
        eng_fixed = 1; eng_lat = 10; eng_val = 8'h5A;
        r0 = rx_cnt[0];
        run_req(0, 1, 8'hC3, 1'b0, 3);
        chk("early_rx0", 8'(rx_cnt[0] - r0), 8'd1);
        chk("early_rx_byte", rx_byte, 8'h5A);
        wait_idle("early_idle");

        // asynchronous reset while requester 0 is mid-byte
        eng_fixed = 1; eng_lat = 30;
        @(negedge clk);
        req_v[0] = 1'b1;
        tx_valid_v[0] = 1'b1;
        tx_byte_v[0] = 8'h99;
        ok = 0;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (tx_ready0) begin
                ok = 1;
                break;
            end
        end
        chk("rst_mid_ready", {7'b0, ok}, 8'h01);
        exp_q.push_back(8'h99);
        @(negedge clk);
        tx_valid_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_cs_n", {6'b0, cs_n}, 8'h03);
        chk("rst_mid_gnt", {6'b0, gnt1, gnt0}, 8'h00);
        chk("rst_mid_state", {5'b0, dbg_state}, 8'h00);
        req_v = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        eng_fixed = 0;
        g0 = gnt_order.size();
        fork
            run_req(0, 1, 8'h00, 1'b1, -1);
            run_req(1, 1, 8'h00, 1'b1, -1);
        join
        wait_idle("rst_tie_idle");
        chk("rst_tie_grants", 8'(gnt_order.size() - g0), 8'd2);
        if (gnt_order.size() >= g0 + 2) begin
            chk("rst_tie_first", 8'(gnt_order[g0]), 8'd0);
            chk("rst_tie_second", 8'(gnt_order[g0 + 1]), 8'd1);
        end

        // randomized traffic
        eng_fixed = 0;
        for (int it = 0; it < 25; it++) begin
            int mode, n0, n1, d0, d1;
            mode = $urandom_range(0, 2);
            n0 = $urandom_range(1, 3);
            n1 = $urandom_range(1, 3);
            d0 = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : -1;
            d1 = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : -1;
            if (mode == 0) run_req(0, n0, 8'h00, 1'b1, d0);
            else if (mode == 1) run_req(1, n1, 8'h00, 1'b1, d1);
            else begin
                fork
                    run_req(0, n0, 8'h00, 1'b1, d0);
                    run_req(1, n1, 8'h00, 1'b1, d1);
                join
            end
            wait_idle("rand_idle");
        end

        chk("exp_q_drained", 8'(exp_q.size()), 8'd0);
        chk("rx_q_drained", 8'(rx_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
